mips_reg_file: RTL and testbench
================================

// Module: mips_reg_file
// PURPOSE
//   General-purpose register file for the MIPS datapath: 1 write port, 2 read ports.
//   Decode stage reads rs/rt through ra1/ra2. Writeback stage writes rd/rt through wa/wd/we.
//   Storage is clocked: writes commit on the rising clk edge, reads are combinational.
//   Register 0 is hardwired to zero.
// PARAMETERS
//   DATA_W    32  width of each register and of the wd/rd1/rd2 data
//   ADDR_W    5   width of the wa/ra1/ra2 addresses
//   NUM_REGS  32  number of implemented registers; must be <= 2**ADDR_W
// PORTS
//   clk    in   1       clock; all state changes on the rising edge
//   reset  in   1       synchronous, active-high; clears all registers
//   we     in   1       write enable, sampled on the rising clk edge
//   wa     in   ADDR_W  write address
//   wd     in   DATA_W  write data
//   ra1    in   ADDR_W  read address, port 1 (rs)
//   ra2    in   ADDR_W  read address, port 2 (rt)
//   rd1    out  DATA_W  read data, port 1
//   rd2    out  DATA_W  read data, port 2
// BEHAVIOUR
//   - Interface: one clock (clk); reset is synchronous and active-high (reset).
//   - Reset: reset=1 at a rising edge sets every register to 0.
//     * Reset has priority over a write in the same cycle.
//     * rd1/rd2 read 0 from the first edge with reset=1 and stay 0 until a later write.
//     * Before the first reset edge, contents are undefined (X in sim).
//   - Write: at a rising edge with reset=0 and we=1, regs[wa] <= wd.
//     * The write is ignored when wa==0 or wa>=NUM_REGS.
//     * Write latency: 1 edge. The new value is visible on rd* after that edge.
//   - Read: rdN = regs[raN], combinational, no clock.
//     * raN==0 or raN>=NUM_REGS -> rdN = 0.
//     * Both ports are independent; ra1==ra2 is legal and gives equal data.
//   - Same-cycle read/write of one address: behaviour depends on the macro under
//     CONFIGURATION. Default is the old value until the edge.
//   - we=1 with wd containing X/Z: the stored value is X. No checking.
//   - No internal FSM beyond storage.
//   - rd1/rd2 never glitch to X from a write to an unrelated address.
// CONFIGURATION
//   REGFILE_BYPASS_EN
//     - Defined: write-to-read forwarding.
//       * If reset==0, we==1, wa!=0, wa<NUM_REGS and raN==wa, then rdN = wd in the same cycle.
//       * Otherwise rdN follows the normal read rule.
//       * No forwarding while reset==1.
//       * This resolves the WB->ID hazard without a half-cycle write.
//     - Undefined: no forwarding. rdN shows the stored value; the new value appears after the edge.
// TESTING
//   1 Reset: reset=1 for 1 edge, then sweep ra1/ra2 over 0..31 -> all rd1/rd2 = 0.
//   2 Write/read: we=1, wa=5, wd=32'h0000_00A5, edge; ra1=5 -> rd1=32'hA5.
//     ra2=6 -> rd2=0.
//   3 Zero register: we=1, wa=0, wd=32'hFFFF_FFFF, edge; ra1=0 -> rd1=0.
//   4 Reset priority: reset=1, we=1, wa=7, wd=32'd9, edge; ra1=7 -> rd1=0.
//   5 Same-cycle hazard: reg 3 holds 32'd2; we=1, wa=3, wd=32'd5, ra1=3 before the edge.
//     * Without the macro: rd1=2, then 5 after the edge.
//     * With REGFILE_BYPASS_EN: rd1=5 before the edge.
//   6 Dual port: write regs 1=32'd10 and 31=32'd20; ra1=1, ra2=31 -> rd1=10, rd2=20.
//     Then ra1=ra2=31 -> both ports = 20.

Source files
------------

// File: rtl/mips_reg_file.sv
// MIPS general-purpose register file: one clocked write port, two combinational read ports.
// Register 0 reads as zero. Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module mips_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  // Register 0 has no storage; index decode by loop keeps out-of-range addresses inert.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wa == ADDR_W'(i)) regs[i] <= wd;
      end
    end
  end

  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ra1 == ADDR_W'(i)) stored1 = regs[i];
      if (ra2 == ADDR_W'(i)) stored2 = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wa_valid;
  logic fwd1;
  logic fwd2;

  always_comb begin
    wa_valid = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wa == ADDR_W'(i)) wa_valid = 1'b1;
    end
  end

  // Forwarding resolves the WB->ID hazard; suppressed while reset clears the file.
  assign fwd1 = !reset && we && wa_valid && (ra1 == wa);
  assign fwd2 = !reset && we && wa_valid && (ra2 == wa);
  assign rd1  = fwd1 ? wd : stored1;
  assign rd2  = fwd2 ? wd : stored2;
`else
  assign rd1 = stored1;
  assign rd2 = stored2;
`endif

endmodule

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file: table-driven post-edge vectors plus
// hand sequences for the reset sweep and same-cycle read/write hazard.
module tb_mips_reg_file;
  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks   = 0;
  int failures = 0;

  mips_reg_file dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Expected values are read one edge after the vector is applied.
    vecs[0] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b1, 5'd5,  32'h0000_00A5, 5'd5, 5'd6,  32'hA5,       32'h0};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd5,  32'h0,        32'hA5};
    vecs[3] = '{1'b0, 1'b1, 5'd7,  32'd9,        5'd7,  5'd5,  32'd9,        32'hA5};
    vecs[4] = '{1'b1, 1'b1, 5'd7,  32'd9,        5'd7,  5'd5,  32'h0,        32'h0};
    vecs[5] = '{1'b0, 1'b1, 5'd3,  32'd2,        5'd3,  5'd3,  32'd2,        32'd2};
    vecs[6] = '{1'b0, 1'b1, 5'd1,  32'd10,       5'd1,  5'd3,  32'd10,       32'd2};
    vecs[7] = '{1'b0, 1'b1, 5'd31, 32'd20,       5'd1,  5'd31, 32'd10,       32'd20};
    vecs[8] = '{1'b0, 1'b0, 5'd1,  32'hDEAD,     5'd31, 5'd31, 32'd20,       32'd20};
    vecs[9] = '{1'b0, 1'b1, 5'd1,  32'hDEAD_BEEF, 5'd1, 5'd31, 32'hDEAD_BEEF, 32'd20};

    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      reset = vecs[v].reset; we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
      ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
      @(posedge clk); #1;
      check($sformatf("vec%0d_rd1", v), rd1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), rd2, vecs[v].exp2);

      // After the first reset edge, sweep every address on both ports.
      if (v == 0) begin
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
          ra1 = 5'(a); ra2 = 5'(31 - a);
          #1;
          check($sformatf("sweep_rd1_%0d", a), rd1, 32'h0);
          check($sformatf("sweep_rd2_%0d", 31 - a), rd2, 32'h0);
        end
      end
    end

    // Same-cycle hazard on reg 3 (holds 2); port 2 watches an unrelated register.
    @(negedge clk);
    reset = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'd5; ra1 = 5'd3; ra2 = 5'd1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_pre_edge", rd1, 32'd5);
`else
    check("hazard_pre_edge", rd1, 32'd2);
`endif
    check("hazard_unrelated_pre", rd2, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("hazard_post_edge", rd1, 32'd5);
    check("hazard_unrelated_post", rd2, 32'hDEAD_BEEF);

    // Reset while a write is pending: no forwarding, everything clears.
    @(negedge clk);
    reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'd77; ra1 = 5'd3; ra2 = 5'd31;
    #1;
    check("reset_no_fwd_pre", rd1, 32'd5);
    @(posedge clk); #1;
    check("reset_no_fwd_rd1", rd1, 32'h0);
    check("reset_no_fwd_rd2", rd2, 32'h0);

    // Dual port equal addresses after fresh writes.
    @(negedge clk);
    reset = 1'b0; we = 1'b1; wa = 5'd31; wd = 32'd20; ra1 = 5'd31; ra2 = 5'd31;
    @(posedge clk); #1;
    @(negedge clk);
    we = 1'b0;
    #1;
    check("same_addr_rd1", rd1, 32'd20);
    check("same_addr_rd2", rd2, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
